// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, SP and carry operations, CCR bit positions.
package ex_stage_pkg;

  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_NOT  = 4'h1;
  localparam logic [3:0] ALU_INC  = 4'h2;
  localparam logic [3:0] ALU_DEC  = 4'h3;
  localparam logic [3:0] ALU_ADD  = 4'h4;
  localparam logic [3:0] ALU_SUB  = 4'h5;
  localparam logic [3:0] ALU_AND  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_SHL  = 4'h8;
  localparam logic [3:0] ALU_SHR  = 4'h9;
  localparam logic [3:0] ALU_MOV  = 4'hA;

  typedef enum logic [1:0] {
    SP_NONE  = 2'b00,
    SP_PUSH  = 2'b01,
    SP_POP   = 2'b10,
    SP_NONE3 = 2'b11
  } sp_op_e;

  typedef enum logic [1:0] {
    CARRY_NONE  = 2'b00,
    CARRY_SET   = 2'b01,
    CARRY_CLR   = 2'b10,
    CARRY_NONE3 = 2'b11
  } carry_op_e;

  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;

  // Only the arithmetic/logic/shift group (NOT..SHR) may touch Z/N/C.
  function automatic logic flagsAffected(input logic [3:0] op);
    return (op >= ALU_NOT) && (op <= ALU_SHR);
  endfunction

endpackage

// File: rtl/ex_stage_alu_unit.sv
// Combinational ALU: result plus a carry that is only meaningful when carryValid_o is set.
module alu_unit
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carryValid_o,
  output logic              carry_o
);

  logic [DATA_W:0] sumExt;
  logic [DATA_W:0] diffExt;
  logic [DATA_W:0] incExt;
  logic [DATA_W:0] decExt;
  logic [DATA_W:0] shlExt;
  logic [DATA_W:0] shrExt;
  logic [3:0]      shAmt;

  // One spare bit on each side captures carry/borrow and the last bit shifted out.
  assign shAmt   = b_i[3:0];
  assign sumExt  = {1'b0, a_i} + {1'b0, b_i};
  assign diffExt = {1'b0, a_i} - {1'b0, b_i};
  assign incExt  = {1'b0, a_i} + (DATA_W+1)'(1);
  assign decExt  = {1'b0, a_i} - (DATA_W+1)'(1);
  assign shlExt  = {1'b0, a_i} << shAmt;
  assign shrExt  = {a_i, 1'b0} >> shAmt;

  always_comb begin
    res_o        = a_i;
    carryValid_o = 1'b0;
    carry_o      = 1'b0;
    case (op_i)
      ALU_PASS: res_o = a_i;
      ALU_NOT:  res_o = ~a_i;
      ALU_INC: begin
        res_o        = incExt[DATA_W-1:0];
        carryValid_o = 1'b1;
        carry_o      = incExt[DATA_W];
      end
      ALU_DEC: begin
        res_o        = decExt[DATA_W-1:0];
        carryValid_o = 1'b1;
        carry_o      = decExt[DATA_W];
      end
      ALU_ADD: begin
        res_o        = sumExt[DATA_W-1:0];
        carryValid_o = 1'b1;
        carry_o      = sumExt[DATA_W];
      end
      ALU_SUB: begin
        res_o        = diffExt[DATA_W-1:0];
        carryValid_o = 1'b1;
        carry_o      = diffExt[DATA_W];
      end
      ALU_AND:  res_o = a_i & b_i;
      ALU_OR:   res_o = a_i | b_i;
      ALU_SHL: begin
        res_o        = shlExt[DATA_W-1:0];
        carryValid_o = (shAmt != 4'd0);
        carry_o      = shlExt[DATA_W];
      end
      ALU_SHR: begin
        res_o        = shrExt[DATA_W:1];
        carryValid_o = (shAmt != 4'd0);
        carry_o      = shrExt[0];
      end
      ALU_MOV:  res_o = b_i;
      default:  res_o = a_i;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, condition codes, stack pointer and the EX/MEM pipeline registers.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter logic [DATA_W-1:0]  SP_RESET = 16'h03FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              iRegWrite,
  input  logic              iMemWrite,
  input  logic              iMemRead,
  input  logic              iMemOrReg,
  input  logic              iSPOrALUres,
  input  logic              iImmOrReg,
  input  logic              iUpdateStatus,
  input  logic [3:0]        iRegDestAddress,
  input  logic [3:0]        iAluControl,
  input  logic [1:0]        iSPOperation,
  input  logic [1:0]        iCarryOp,
  input  logic [DATA_W-1:0] iRegSrc,
  input  logic [DATA_W-1:0] iRegDest,
  input  logic [DATA_W-1:0] iImm,
  output logic              oRegWrite,
  output logic              oMemWrite,
  output logic              oMemRead,
  output logic              oMemOrReg,
  output logic [3:0]        oRegDestAddress,
  output logic [DATA_W-1:0] oAluRes,
  output logic [DATA_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oStoreData,
  output logic [2:0]        oCCR,
  output logic [DATA_W-1:0] oSP
);

  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluRes;
  logic              aluCarryValid;
  logic              aluCarry;

  logic [2:0]        ccr_q, ccr_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] memAddr_d;

  logic              regWrite_q, memWrite_q, memRead_q, memOrReg_q;
  logic [3:0]        regDestAddr_q;
  logic [DATA_W-1:0] aluRes_q, memAddr_q, storeData_q;

  assign opB = iImmOrReg ? iImm : iRegSrc;

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .a_i          (iRegDest),
    .b_i          (opB),
    .op_i         (iAluControl),
    .res_o        (aluRes),
    .carryValid_o (aluCarryValid),
    .carry_o      (aluCarry)
  );

  // Explicit SETC/CLRC is applied after the ALU flags so it always wins for C.
  always_comb begin
    ccr_d = ccr_q;
    if (iUpdateStatus && flagsAffected(iAluControl)) begin
      ccr_d[CCR_Z] = (aluRes == '0);
      ccr_d[CCR_N] = aluRes[DATA_W-1];
      if (aluCarryValid) ccr_d[CCR_C] = aluCarry;
    end
    if (iCarryOp == CARRY_SET) ccr_d[CCR_C] = 1'b1;
    else if (iCarryOp == CARRY_CLR) ccr_d[CCR_C] = 1'b0;
  end

  // Push addresses the current top, pop addresses the slot it frees.
  always_comb begin
    sp_d      = sp_q;
    memAddr_d = iSPOrALUres ? sp_q : aluRes;
    if (iSPOperation == SP_PUSH) begin
      sp_d      = sp_q - DATA_W'(1);
      memAddr_d = sp_q;
    end else if (iSPOperation == SP_POP) begin
      sp_d      = sp_q + DATA_W'(1);
      memAddr_d = sp_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrite_q    <= 1'b0;
      memWrite_q    <= 1'b0;
      memRead_q     <= 1'b0;
      memOrReg_q    <= 1'b0;
      regDestAddr_q <= '0;
      aluRes_q      <= '0;
      memAddr_q     <= '0;
      storeData_q   <= '0;
      ccr_q         <= 3'b000;
      sp_q          <= SP_RESET;
    end else if (flush) begin
      regWrite_q    <= 1'b0;
      memWrite_q    <= 1'b0;
      memRead_q     <= 1'b0;
      memOrReg_q    <= 1'b0;
      regDestAddr_q <= '0;
      aluRes_q      <= '0;
      memAddr_q     <= '0;
      storeData_q   <= '0;
    end else if (!stall) begin
      regWrite_q    <= iRegWrite;
      memWrite_q    <= iMemWrite;
      memRead_q     <= iMemRead;
      memOrReg_q    <= iMemOrReg;
      regDestAddr_q <= iRegDestAddress;
      aluRes_q      <= aluRes;
      memAddr_q     <= memAddr_d;
      storeData_q   <= iRegDest;
      ccr_q         <= ccr_d;
      sp_q          <= sp_d;
    end
  end

  assign oRegWrite       = regWrite_q;
  assign oMemWrite       = memWrite_q;
  assign oMemRead        = memRead_q;
  assign oMemOrReg       = memOrReg_q;
  assign oRegDestAddress = regDestAddr_q;
  assign oAluRes         = aluRes_q;
  assign oMemAddr        = memAddr_q;
  assign oStoreData      = storeData_q;
  assign oCCR            = ccr_q;
  assign oSP             = sp_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued when driven and checked one edge later.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        iRegWrite, iMemWrite, iMemRead, iMemOrReg, iSPOrALUres, iImmOrReg, iUpdateStatus;
  logic [3:0]  iRegDestAddress, iAluControl;
  logic [1:0]  iSPOperation, iCarryOp;
  logic [15:0] iRegSrc, iRegDest, iImm;
  logic        oRegWrite, oMemWrite, oMemRead, oMemOrReg;
  logic [3:0]  oRegDestAddress;
  logic [15:0] oAluRes, oMemAddr, oStoreData, oSP;
  logic [2:0]  oCCR;

  typedef struct {
    logic [15:0] aluRes;
    logic [15:0] memAddr;
    logic [2:0]  ccr;
    logic [15:0] sp;
    logic [3:0]  ctrl;
    logic [3:0]  dest;
    logic [15:0] storeData;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  int   testCount = 0;
  int   failCount = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .iRegWrite(iRegWrite), .iMemWrite(iMemWrite), .iMemRead(iMemRead), .iMemOrReg(iMemOrReg),
    .iSPOrALUres(iSPOrALUres), .iImmOrReg(iImmOrReg), .iUpdateStatus(iUpdateStatus),
    .iRegDestAddress(iRegDestAddress), .iAluControl(iAluControl),
    .iSPOperation(iSPOperation), .iCarryOp(iCarryOp),
    .iRegSrc(iRegSrc), .iRegDest(iRegDest), .iImm(iImm),
    .oRegWrite(oRegWrite), .oMemWrite(oMemWrite), .oMemRead(oMemRead), .oMemOrReg(oMemOrReg),
    .oRegDestAddress(oRegDestAddress), .oAluRes(oAluRes), .oMemAddr(oMemAddr),
    .oStoreData(oStoreData), .oCCR(oCCR), .oSP(oSP)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Memory controls follow the SP op so the registered control path is exercised too.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] src,
                               input logic [15:0] imm, input logic immOrReg, input logic upd,
                               input logic [1:0] spOp, input logic [1:0] carryOp,
                               input logic spOrAlu, input logic [3:0] dest);
    iAluControl     = op;
    iRegDest        = a;
    iRegSrc         = src;
    iImm            = imm;
    iImmOrReg       = immOrReg;
    iUpdateStatus   = upd;
    iSPOperation    = spOp;
    iCarryOp        = carryOp;
    iSPOrALUres     = spOrAlu;
    iRegDestAddress = dest;
    iRegWrite       = 1'b1;
    iMemWrite       = (spOp == 2'b01);
    iMemRead        = (spOp == 2'b10);
    iMemOrReg       = (spOp == 2'b10);
  endtask

  task automatic expectOut(input logic [15:0] aluRes, input logic [15:0] memAddr, input logic [2:0] ccr,
                           input logic [15:0] sp, input logic [3:0] ctrl, input logic [3:0] dest,
                           input logic [15:0] storeData);
    exp_t e;
    e.aluRes = aluRes; e.memAddr = memAddr; e.ccr = ccr; e.sp = sp;
    e.ctrl = ctrl; e.dest = dest; e.storeData = storeData;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    testCount++;
    assert (expQ.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL %s: scoreboard empty, observed 0 entries expected 1", tag);
      return;
    end
    e = expQ.pop_front();
    lastExp = e;
    chk({tag, ".aluRes"},    oAluRes,    e.aluRes);
    chk({tag, ".memAddr"},   oMemAddr,   e.memAddr);
    chk({tag, ".ccr"},       {13'd0, oCCR}, {13'd0, e.ccr});
    chk({tag, ".sp"},        oSP,        e.sp);
    chk({tag, ".ctrl"},      {12'd0, oRegWrite, oMemWrite, oMemRead, oMemOrReg}, {12'd0, e.ctrl});
    chk({tag, ".dest"},      {12'd0, oRegDestAddress}, {12'd0, e.dest});
    chk({tag, ".storeData"}, oStoreData, e.storeData);
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, ".aluRes"},  oAluRes,    16'h0000);
    chk({tag, ".memAddr"}, oMemAddr,   16'h0000);
    chk({tag, ".store"},   oStoreData, 16'h0000);
    chk({tag, ".ctrl"},    {11'd0, oRegWrite, oMemWrite, oMemRead, oMemOrReg, 1'b0}, 16'h0000);
    chk({tag, ".dest"},    {12'd0, oRegDestAddress}, 16'h0000);
    chk({tag, ".ccr"},     {13'd0, oCCR}, 16'h0000);
    chk({tag, ".sp"},      oSP,        16'h03FF);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    applyStimulus(4'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0);
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'h4, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'h3);
    expectOut(16'h0000, 16'h0000, 3'b101, 16'h03FF, 4'b1000, 4'h3, 16'hFFFF);
    stepCycle("addCarry");

    applyStimulus(4'h5, 16'h0003, 16'h0000, 16'h0005, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'h4);
    expectOut(16'hFFFE, 16'hFFFE, 3'b110, 16'h03FF, 4'b1000, 4'h4, 16'h0003);
    stepCycle("subBorrow");

    applyStimulus(4'h4, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 4'h5);
    expectOut(16'h0003, 16'h0003, 3'b100, 16'h03FF, 4'b1000, 4'h5, 16'h0001);
    stepCycle("setcOverride");

    applyStimulus(4'h0, 16'h0007, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 4'h1);
    expectOut(16'h0007, 16'h0007, 3'b000, 16'h03FF, 4'b1000, 4'h1, 16'h0007);
    stepCycle("clrc");

    applyStimulus(4'h0, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 4'h2);
    expectOut(16'h1234, 16'h03FF, 3'b000, 16'h03FE, 4'b1100, 4'h2, 16'h1234);
    stepCycle("push1");

    applyStimulus(4'h0, 16'h5678, 16'h0, 16'h0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 4'h2);
    expectOut(16'h5678, 16'h03FE, 3'b000, 16'h03FD, 4'b1100, 4'h2, 16'h5678);
    stepCycle("push2");

    applyStimulus(4'h0, 16'h9ABC, 16'h0, 16'h0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 4'h7);
    expectOut(16'h9ABC, 16'h03FE, 3'b000, 16'h03FE, 4'b1011, 4'h7, 16'h9ABC);
    stepCycle("pop");

    applyStimulus(4'h4, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'h8);
    expectOut(16'h0002, 16'h03FE, 3'b000, 16'h03FE, 4'b1000, 4'h8, 16'h0001);
    stepCycle("spAddr");

    applyStimulus(4'h8, 16'h8001, 16'h0, 16'h0001, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'h9);
    expectOut(16'h0002, 16'h0002, 3'b100, 16'h03FE, 4'b1000, 4'h9, 16'h8001);
    stepCycle("shl1");

    applyStimulus(4'h9, 16'h8000, 16'h0, 16'h0000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'hA);
    expectOut(16'h8000, 16'h8000, 3'b110, 16'h03FE, 4'b1000, 4'hA, 16'h8000);
    stepCycle("shr0");

    applyStimulus(4'h9, 16'h0002, 16'h0, 16'h0001, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'hB);
    expectOut(16'h0001, 16'h0001, 3'b000, 16'h03FE, 4'b1000, 4'hB, 16'h0002);
    stepCycle("shr1");

    applyStimulus(4'h2, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'hC);
    expectOut(16'h0000, 16'h0000, 3'b101, 16'h03FE, 4'b1000, 4'hC, 16'hFFFF);
    stepCycle("inc");

    applyStimulus(4'h3, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'hD);
    expectOut(16'hFFFF, 16'hFFFF, 3'b110, 16'h03FE, 4'b1000, 4'hD, 16'h0000);
    stepCycle("dec");

    applyStimulus(4'h6, 16'hF0F0, 16'h0F0F, 16'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'hE);
    expectOut(16'h0000, 16'h0000, 3'b101, 16'h03FE, 4'b1000, 4'hE, 16'hF0F0);
    stepCycle("and");

    applyStimulus(4'hA, 16'h1111, 16'h2222, 16'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'hF);
    expectOut(16'h2222, 16'h2222, 3'b101, 16'h03FE, 4'b1000, 4'hF, 16'h1111);
    stepCycle("mov");

    applyStimulus(4'h1, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'h6);
    expectOut(16'hFF00, 16'hFF00, 3'b110, 16'h03FE, 4'b1000, 4'h6, 16'h00FF);
    stepCycle("not");

    stall = 1'b1;
    applyStimulus(4'h4, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 4'h3);
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(lastExp);
      stepCycle("stall");
    end

    flush = 1'b1;
    expectOut(16'h0000, 16'h0000, 3'b110, 16'h03FE, 4'b0000, 4'h0, 16'h0000);
    stepCycle("flush");
    flush = 1'b0;
    stall = 1'b0;

    applyStimulus(4'hB, 16'h4321, 16'h0005, 16'h0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'h2);
    expectOut(16'h4321, 16'h4321, 3'b110, 16'h03FE, 4'b1000, 4'h2, 16'h4321);
    stepCycle("opB");

    // Asynchronous reset lands between edges while an ADD with push is on the inputs.
    applyStimulus(4'h4, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 4'h3);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midReset");
    @(negedge clk);
    checkReset("heldReset");
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++) begin
      applyStimulus(4'h0, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 4'h1);
      @(posedge clk);
      #1;
    end
    chk("spWrapDown", oSP, 16'hFFFF);

    applyStimulus(4'h0, 16'hABCD, 16'h0, 16'h0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 4'h4);
    expectOut(16'hABCD, 16'h0000, 3'b000, 16'h0000, 4'b1011, 4'h4, 16'hABCD);
    stepCycle("popWrap");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
